// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch unit with a 2-entry decode FIFO.
//
// Issues word-aligned fetch requests from a fetch PC, tracks outstanding
// requests against a 2-credit budget so the FIFO can never overflow, and
// discards responses that belong to requests issued before a redirect.
//
// Ports:
//   clk_in, rst_in                    clock, synchronous active-high reset
//   imem_req_out/imem_addr_out        fetch request and word address
//   imem_gnt_in                       request accepted when req & gnt
//   imem_rvalid_in/imem_rdata_in      in-order response
//   redirect_in/redirect_pc_in        branch/jump redirect and target
//   instr_out/pc_out/instr_valid_out  FIFO head presented to decode
//   instr_ready_in                    decode ready (transfer on valid & ready)
//   fetch_err_out                     misaligned redirect target flag
//
// Configuration: define FRISCV_FETCH_MISALIGN_EN to enable misaligned-target
// detection (adds fetch_err_out). Without it, redirect_pc_in[1:0] is ignored.
module instr_fetch #(
  parameter int unsigned     ARCH         = 32,
  parameter logic [ARCH-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic            imem_req_out,
  output logic [ARCH-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [ARCH-1:0] imem_rdata_in,
  input  logic            redirect_in,
  input  logic [ARCH-1:0] redirect_pc_in,
  output logic [ARCH-1:0] instr_out,
  output logic [ARCH-1:0] pc_out,
  output logic            instr_valid_out,
  input  logic            instr_ready_in
`ifdef FRISCV_FETCH_MISALIGN_EN
  ,
  output logic            fetch_err_out
`endif
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;

  // Fetch PC, credit counters and FIFO storage
  logic [ARCH-1:0]  r_fpc;
  logic [CNT_W-1:0] r_outst;
  logic [CNT_W-1:0] r_disc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [ARCH-1:0]  r_fifo_pc    [2];
  logic [ARCH-1:0]  r_fifo_instr [2];

  logic             w_err;
  logic             w_misalign;
  logic [ARCH-1:0]  w_target;
  logic             w_valid;
  logic             w_pop;
  logic [SUM_W-1:0] w_used;
  logic             w_req;
  logic             w_acc;
  logic             w_rsp_drop;
  logic             w_rsp_keep;
  logic [SUM_W-1:0] w_inflight;
  logic [ARCH-1:0]  w_rsp_pc;

`ifdef FRISCV_FETCH_MISALIGN_EN
  logic r_err;

  assign w_err       = r_err & ~rst_in;
  assign w_misalign  = redirect_in & (redirect_pc_in[1:0] != 2'b00);
  assign w_target    = redirect_pc_in;
  assign fetch_err_out = w_err;
`else
  assign w_err       = 1'b0;
  assign w_misalign  = 1'b0;
  assign w_target    = redirect_pc_in & ~ARCH'(3);
`endif

  // Decode handshake on the FIFO head
  assign w_valid = ~rst_in & (r_cnt != '0);
  assign w_pop   = w_valid & instr_ready_in;

  // Credit rule: outstanding + pending discards + occupancy after this
  // cycle's pop must stay below 2. That sum never grows without a grant,
  // so a raised request stays raised until it is granted or redirected.
  assign w_used = SUM_W'(r_outst) + SUM_W'(r_disc) + SUM_W'(r_cnt) - SUM_W'(w_pop);
  assign w_req  = ~rst_in & ~redirect_in & ~w_err & (w_used < SUM_W'(2));
  assign w_acc  = w_req & imem_gnt_in;

  // Responses pay off discards first, then live requests
  assign w_rsp_drop = imem_rvalid_in & (r_disc != '0);
  assign w_rsp_keep = imem_rvalid_in & (r_disc == '0) & (r_outst != '0);

  // Live requests are consecutive words, so the oldest one sits
  // outstanding*4 bytes behind the fetch PC.
  assign w_rsp_pc = r_fpc - (ARCH'(r_outst) << 2);

  // Requests still in flight after this cycle, all discarded on redirect
  assign w_inflight = SUM_W'(r_outst) + SUM_W'(r_disc) + SUM_W'(w_acc)
                    - SUM_W'(w_rsp_drop | w_rsp_keep);

  // Outputs
  assign imem_req_out    = w_req;
  assign imem_addr_out   = r_fpc;
  assign instr_valid_out = w_valid;
  assign instr_out       = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
  assign pc_out          = w_err   ? r_fpc :
                           w_valid ? r_fifo_pc[r_rd_ptr] : '0;

  // Fetch PC and credit counters
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fpc   <= RESET_VECTOR;
      r_outst <= '0;
      r_disc  <= '0;
    end else if (redirect_in) begin
      r_fpc   <= w_target;
      r_outst <= '0;
      r_disc  <= CNT_W'(w_inflight);
    end else begin
      if (w_acc) r_fpc <= r_fpc + ARCH'(4);
      r_outst <= r_outst + CNT_W'(w_acc) - CNT_W'(w_rsp_keep);
      if (w_rsp_drop) r_disc <= r_disc - CNT_W'(1);
    end
  end

`ifdef FRISCV_FETCH_MISALIGN_EN
  // Error latches on a misaligned redirect, clears on an aligned one
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err <= 1'b0;
    end else if (redirect_in) begin
      r_err <= w_misalign;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_misalign;
`endif

  // Decode FIFO control; redirect flushes and wins over push and pop
  always_ff @(posedge clk_in) begin
    if (rst_in || redirect_in) begin
      r_cnt    <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_rsp_keep) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + CNT_W'(w_rsp_keep) - CNT_W'(w_pop);
    end
  end

  // Decode FIFO storage
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fifo_pc[0]    <= '0;
      r_fifo_pc[1]    <= '0;
      r_fifo_instr[0] <= '0;
      r_fifo_instr[1] <= '0;
    end else if (w_rsp_keep && !redirect_in) begin
      r_fifo_pc[r_wr_ptr]    <= w_rsp_pc;
      r_fifo_instr[r_wr_ptr] <= imem_rdata_in;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory model with programmable
// response latency, plus request and decode scoreboards fed with
// hand-computed expected addresses and PCs.
module tb_instr_fetch;

  localparam int unsigned ARCH = 32;

  logic            clk_in;
  logic            rst_in;
  logic            imem_req_out;
  logic [ARCH-1:0] imem_addr_out;
  logic            imem_gnt_in;
  logic            imem_rvalid_in;
  logic [ARCH-1:0] imem_rdata_in;
  logic            redirect_in;
  logic [ARCH-1:0] redirect_pc_in;
  logic [ARCH-1:0] instr_out;
  logic [ARCH-1:0] pc_out;
  logic            instr_valid_out;
  logic            instr_ready_in;
`ifdef FRISCV_FETCH_MISALIGN_EN
  logic            fetch_err_out;
`endif

  instr_fetch #(.ARCH(ARCH), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in)
`ifdef FRISCV_FETCH_MISALIGN_EN
    ,
    .fetch_err_out   (fetch_err_out)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_cnt  = 0;
  int          lat      = 1;
  int          acc_cnt  = 0;
  int          dlv_cnt  = 0;
  int          first_dlv = -1;
  int          last_dlv  = -1;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_pc_q   [$];
  mem_t        mem_q      [$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in      = 1'b1;
    redirect_in = 1'b0;
    imem_gnt_in = 1'b0;
    instr_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    acc_cnt   = 0;
    dlv_cnt   = 0;
    first_dlv = -1;
    last_dlv  = -1;
    rst_in    = 1'b0;
  endtask

  task automatic drain_check(input string name);
    check({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, "_pc_left"},   32'(exp_pc_q.size()),   32'd0);
  endtask

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory model: in-order responses 'lat' cycles after grant, reset with DUT
  initial begin
    mem_t m;
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = '0;
    forever begin
      @(negedge clk_in);
      #1;
      cyc_cnt++;
      imem_rvalid_in = 1'b0;
      imem_rdata_in  = '0;
      if (rst_in) begin
        mem_q.delete();
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc_cnt) begin
        m = mem_q.pop_front();
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = instr_of(m.addr);
      end
    end
  end

  // Request monitor: every accepted request must match the next expected address
  initial begin
    mem_t m;
    forever begin
      @(negedge clk_in);
      #3;
      if (!rst_in && imem_req_out && imem_gnt_in) begin
        acc_cnt++;
        m.addr = imem_addr_out;
        m.due  = cyc_cnt + lat;
        mem_q.push_back(m);
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_addr: got request 0x%08h, expected none", imem_addr_out);
        end else begin
          check("req_addr", imem_addr_out, exp_addr_q.pop_front());
        end
      end
    end
  end

  // Decode monitor: every transfer must match the next expected PC/instruction
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_in);
      #3;
      if (!rst_in && instr_valid_out && instr_ready_in && !redirect_in) begin
        dlv_cnt++;
        if (first_dlv < 0) first_dlv = cyc_cnt;
        last_dlv = cyc_cnt;
        if (exp_pc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dec_pc: got delivery pc 0x%08h, expected none", pc_out);
        end else begin
          e = exp_pc_q.pop_front();
          check("dec_pc", pc_out, e);
          check("dec_instr", instr_out, instr_of(e));
        end
      end
    end
  end

  initial begin
    rst_in         = 1'b1;
    imem_gnt_in    = 1'b0;
    redirect_in    = 1'b0;
    redirect_pc_in = '0;
    instr_ready_in = 1'b0;

    // Reset state
    @(negedge clk_in);
    #4;
    check("rst_req",   32'(imem_req_out),    32'd0);
    check("rst_valid", 32'(instr_valid_out), 32'd0);
    check("rst_instr", instr_out,            32'd0);
    check("rst_pc",    pc_out,               32'd0);
    check("rst_addr",  imem_addr_out,        32'd0);
`ifdef FRISCV_FETCH_MISALIGN_EN
    check("rst_err",   32'(fetch_err_out),   32'd0);
`endif

    // Streaming from reset: one instruction per cycle, then grant held low
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_pc_q.push_back(32'(i * 4));
    end
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b1;
    #4;
    check("t1_first_req",  32'(imem_req_out), 32'd1);
    check("t1_first_addr", imem_addr_out,     32'h0);
    repeat (8) next();
    imem_gnt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("t1_hold_req",  32'(imem_req_out), 32'd1);
      check("t1_hold_addr", imem_addr_out,     32'h20);
      next();
    end
    repeat (2) next();
    check("t1_dlv_cnt", 32'(dlv_cnt), 32'd8);
    check("t1_span",    32'(last_dlv - first_dlv), 32'd7);
    drain_check("t1");

    // Decode stalled: only two requests, FIFO holds 0x0 / 0x4 in order
    lat = 1;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b0;
    repeat (4) next();
    #4;
    check("t2_valid", 32'(instr_valid_out), 32'd1);
    check("t2_head_pc", pc_out, 32'h0);
    check("t2_head_instr", instr_out, instr_of(32'h0));
    next();
    imem_gnt_in = 1'b0;
    instr_ready_in = 1'b1;
    check("t2_req_count", 32'(acc_cnt), 32'd2);
    repeat (4) next();
    drain_check("t2");

    // Redirect to 0x100 with two requests outstanding
    lat = 3;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    exp_pc_q.push_back(32'h100);
    exp_pc_q.push_back(32'h104);
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b1;
    repeat (2) next();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h100;
    #4;
    check("t3_redir_req", 32'(imem_req_out), 32'd0);
    next();
    redirect_in = 1'b0;
    #4;
    check("t3_discard_req", 32'(imem_req_out), 32'd0);
    next();
    #4;
    check("t3_target_req",  32'(imem_req_out), 32'd1);
    check("t3_target_addr", imem_addr_out,     32'h100);
    repeat (2) next();
    imem_gnt_in = 1'b0;
    repeat (6) next();
    drain_check("t3");

    // Redirect together with a response and a ready FIFO head
    lat = 1;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h44);
    exp_pc_q.push_back(32'h40);
    exp_pc_q.push_back(32'h44);
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b1;
    repeat (2) next();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h40;
    next();
    redirect_in = 1'b0;
    #4;
    check("t4_flushed_valid", 32'(instr_valid_out), 32'd0);
    check("t4_flushed_instr", instr_out, 32'd0);
    check("t4_flushed_pc",    pc_out,    32'd0);
    check("t4_target_addr",   imem_addr_out, 32'h40);
    next();
    #4;
    check("t4_still_empty", 32'(instr_valid_out), 32'd0);
    next();
    imem_gnt_in = 1'b0;
    repeat (4) next();
    drain_check("t4");

    // Back-to-back redirects accumulate discards
    lat = 3;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'hC0);
    exp_addr_q.push_back(32'hC4);
    exp_pc_q.push_back(32'hC0);
    exp_pc_q.push_back(32'hC4);
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b1;
    repeat (2) next();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h80;
    next();
    redirect_pc_in = 32'hC0;
    next();
    redirect_in = 1'b0;
    #4;
    check("t5_req",  32'(imem_req_out), 32'd1);
    check("t5_addr", imem_addr_out,     32'hC0);
    repeat (2) next();
    imem_gnt_in = 1'b0;
    repeat (6) next();
    drain_check("t5");

    // Reset in the middle of traffic drops in-flight responses
    lat = 2;
    do_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b1;
    repeat (3) next();
    rst_in = 1'b1;
    #4;
    check("t6_rst_req",   32'(imem_req_out),    32'd0);
    check("t6_rst_valid", 32'(instr_valid_out), 32'd0);
    repeat (2) next();
    rst_in = 1'b0;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    #4;
    check("t6_resume_req",  32'(imem_req_out), 32'd1);
    check("t6_resume_addr", imem_addr_out,     32'h0);
    repeat (2) next();
    imem_gnt_in = 1'b0;
    repeat (4) next();
    drain_check("t6");

    // Misaligned redirect target
    lat = 1;
    do_reset();
    imem_gnt_in = 1'b1;
    instr_ready_in = 1'b1;
`ifdef FRISCV_FETCH_MISALIGN_EN
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h200);
    exp_pc_q.push_back(32'h200);
    next();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h102;
    next();
    redirect_in = 1'b0;
    #4;
    check("t7_err",   32'(fetch_err_out),   32'd1);
    check("t7_pc",    pc_out,               32'h102);
    check("t7_req",   32'(imem_req_out),    32'd0);
    check("t7_valid", 32'(instr_valid_out), 32'd0);
    repeat (2) next();
    #4;
    check("t7_err_held", 32'(fetch_err_out), 32'd1);
    check("t7_req_held", 32'(imem_req_out),  32'd0);
    next();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h200;
    next();
    redirect_in = 1'b0;
    #4;
    check("t7_err_clear", 32'(fetch_err_out), 32'd0);
    check("t7_req2",      32'(imem_req_out),  32'd1);
    check("t7_addr2",     imem_addr_out,      32'h200);
    next();
`else
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h104);
    exp_pc_q.push_back(32'h104);
    next();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h106;
    next();
    redirect_in = 1'b0;
    #4;
    check("t7_req",  32'(imem_req_out), 32'd1);
    check("t7_addr", imem_addr_out,     32'h104);
    next();
`endif
    imem_gnt_in = 1'b0;
    repeat (4) next();
    drain_check("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
